// File: rtl/dac_sample_sched_pkg.sv
// Shared types and constants for the DAC sample scheduler.
package dac_sample_sched_pkg;

  localparam int DAC_DW = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_GRANT = 2'd2
  } state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dac_sample_sched_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr, wrapping, wins.
module rr_arbiter
  import dac_sample_sched_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IW   = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_id,
  output logic            any
);

  localparam int SW = IW + 1;

  // (p + k) mod NREQ; p < NREQ and k < NREQ, so one conditional subtract is enough.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int k);
    logic [SW-1:0] s;
    s = {1'b0, p} + SW'(k);
    if (s >= SW'(NREQ)) s = s - SW'(NREQ);
    return s[IW-1:0];
  endfunction

  // Walk from the farthest candidate back to ptr so the nearest valid one is kept.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[rr_idx(ptr, k)]) begin
        gnt                 = '0;
        gnt[rr_idx(ptr, k)] = 1'b1;
        gnt_id              = rr_idx(ptr, k);
        any                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_sample_sched.sv
// DAC sample scheduler: programmable sample tick, one round-robin grant per
// tick, registered DAC word with a single-cycle update strobe.
module dac_sample_sched
  import dac_sample_sched_pkg::*;
#(
  parameter  int NREQ  = 2,
  parameter  int DW    = DAC_DW,
  parameter  int DIV_W = 16,
  localparam int GW    = id_width(NREQ)
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               enable,
  input  logic [DIV_W-1:0]   div,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [DW-1:0]      dac_d,
  output logic               dac_strobe,
  output logic [GW-1:0]      grant_id,
  output logic               underrun
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_eff;
  logic [GW-1:0]    ptr_q, ptr_nxt;
  logic [DW-1:0]    dac_d_q;
  logic [GW-1:0]    grant_id_q;
  logic             strobe_q;
  logic             underrun_q;
  logic             tick;
  logic             fire;
  logic [NREQ-1:0]  arb_gnt;
  logic [GW-1:0]    arb_id;
  logic             arb_any;
  logic [DW-1:0]    sel_data;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  // Period counter; div=0 is treated as div=1 so a period is never shorter than 2 cycles.
  always_comb begin
    div_eff = (div == '0) ? DIV_W'(1) : div;
    tick    = (state_q != S_IDLE) && enable && (cnt_q >= div_eff);
    if (!enable || state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // Next-state logic; GRANT always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (enable) state_d = S_COUNT;
      S_COUNT: begin
        if (!enable)   state_d = S_IDLE;
        else if (tick) state_d = S_GRANT;
      end
      S_GRANT: state_d = enable ? S_COUNT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Transfer qualification, winner data mux and pointer advance.
  always_comb begin
    fire      = (state_q == S_GRANT) && enable;
    req_ready = (fire && reset) ? arb_gnt : '0;
    ptr_nxt   = (arb_id == GW'(NREQ - 1)) ? '0 : arb_id + GW'(1);
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_id == GW'(i)) sel_data = req_data[i*DW +: DW];
    end
  end

  // State and counter registers.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output registers: a grant updates the DAC word, an empty grant flags underrun.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      ptr_q      <= '0;
      dac_d_q    <= '0;
      grant_id_q <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      strobe_q   <= fire && arb_any;
      underrun_q <= fire && !arb_any;
      if (fire && arb_any) begin
        dac_d_q    <= sel_data;
        grant_id_q <= arb_id;
        ptr_q      <= ptr_nxt;
      end
    end
  end

  assign dac_d      = dac_d_q;
  assign dac_strobe = strobe_q;
  assign grant_id   = grant_id_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_dac_sample_sched.sv
// Testbench for dac_sample_sched with NREQ=2, DW=10, DIV_W=16.
// Expected grants are queued when a scenario is set up and popped on each strobe.
module tb_dac_sample_sched;

  logic        CLK;
  logic        reset;
  logic        enable;
  logic [15:0] div;
  logic [1:0]  req_valid;
  logic [19:0] req_data;
  logic [1:0]  req_ready;
  logic [9:0]  dac_d;
  logic        dac_strobe;
  logic [0:0]  grant_id;
  logic        underrun;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic [9:0] d;
    logic [0:0] id;
    logic [1:0] rdy;
  } exp_t;

  exp_t sb_q[$];

  dac_sample_sched #(.NREQ(2), .DW(10), .DIV_W(16)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .enable     (enable),
    .div        (div),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .dac_d      (dac_d),
    .dac_strobe (dac_strobe),
    .grant_id   (grant_id),
    .underrun   (underrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic push_exp(input int cyc, input logic [9:0] d, input int id);
    exp_t e;
    e.cyc = cyc;
    e.d   = d;
    e.id  = 1'(id);
    e.rdy = 2'(1 << id);
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    enable = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    enable    = 1'b1;
    div       = 16'd4;
    req_valid = 2'b11;
    req_data  = {10'h2AA, 10'h155};
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      n_chk++; if (dac_d !== 10'h000) begin n_fail++; $display("FAIL reset_dac_d: got %0h expected 0", dac_d); end
      n_chk++; if (dac_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %0b expected 0", dac_strobe); end
      n_chk++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %0b expected 00", req_ready); end
      n_chk++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %0b expected 0", underrun); end
    end
  endtask

  // div=4 -> P=5; first tick at cycle 5, strobe at 7, then every 5 cycles.
  task automatic test_single_source();
    exp_t e;
    logic [1:0] prev_rdy;
    prev_rdy = '0;
    do_reset();
    div = 16'd4; req_valid = 2'b01; req_data = {10'h000, 10'h155}; enable = 1'b1;
    for (int k = 0; k < 3; k++) push_exp(7 + 5*k, 10'h155, 0);
    for (int c = 1; c <= 18; c++) begin
      @(negedge CLK);
      if (dac_strobe) begin
        if (sb_q.size() == 0) begin
          n_chk++; n_fail++; $display("FAIL single_extra_strobe: strobe at cycle %0d, expected none", c);
        end else begin
          e = sb_q.pop_front();
          n_chk++; if (c !== e.cyc) begin n_fail++; $display("FAIL single_strobe_cycle: got %0d expected %0d", c, e.cyc); end
          n_chk++; if (dac_d !== e.d) begin n_fail++; $display("FAIL single_dac_d: got %0h expected %0h", dac_d, e.d); end
          n_chk++; if (grant_id !== e.id) begin n_fail++; $display("FAIL single_grant_id: got %0d expected %0d", grant_id, e.id); end
          n_chk++; if (prev_rdy !== e.rdy) begin n_fail++; $display("FAIL single_ready: got %0b expected %0b", prev_rdy, e.rdy); end
        end
      end
      prev_rdy = req_ready;
    end
    n_chk++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL single_missing: %0d strobes outstanding, expected 0", sb_q.size()); end
    sb_q.delete();
  endtask

  // div=3 -> P=4; both sources valid, grants alternate starting at requester 0.
  task automatic test_round_robin();
    exp_t e;
    logic [1:0] prev_rdy;
    prev_rdy = '0;
    do_reset();
    div = 16'd3; req_valid = 2'b11; req_data = {10'h001, 10'h3FF}; enable = 1'b1;
    for (int k = 0; k < 4; k++) push_exp(6 + 4*k, (k % 2 == 0) ? 10'h3FF : 10'h001, k % 2);
    for (int c = 1; c <= 18; c++) begin
      @(negedge CLK);
      n_chk++; if ($countones(req_ready) > 1) begin n_fail++; $display("FAIL rr_onehot: got %0b expected at most one bit", req_ready); end
      if (dac_strobe) begin
        if (sb_q.size() == 0) begin
          n_chk++; n_fail++; $display("FAIL rr_extra_strobe: strobe at cycle %0d, expected none", c);
        end else begin
          e = sb_q.pop_front();
          n_chk++; if (c !== e.cyc) begin n_fail++; $display("FAIL rr_strobe_cycle: got %0d expected %0d", c, e.cyc); end
          n_chk++; if (dac_d !== e.d) begin n_fail++; $display("FAIL rr_dac_d: got %0h expected %0h", dac_d, e.d); end
          n_chk++; if (grant_id !== e.id) begin n_fail++; $display("FAIL rr_grant_id: got %0d expected %0d", grant_id, e.id); end
          n_chk++; if (prev_rdy !== e.rdy) begin n_fail++; $display("FAIL rr_ready: got %0b expected %0b", prev_rdy, e.rdy); end
        end
      end
      prev_rdy = req_ready;
    end
    n_chk++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL rr_missing: %0d strobes outstanding, expected 0", sb_q.size()); end
    sb_q.delete();
  endtask

  // div=2 -> P=3 with nothing valid; dac_d keeps the 10'h001 left by the previous test.
  task automatic test_underrun();
    logic exp_u;
    enable = 1'b0;
    @(negedge CLK);
    div = 16'd2; req_valid = 2'b00; enable = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge CLK);
      exp_u = (c >= 5) && ((c - 5) % 3 == 0);
      n_chk++; if (underrun !== exp_u) begin n_fail++; $display("FAIL underrun_pulse: cycle %0d got %0b expected %0b", c, underrun, exp_u); end
      n_chk++; if (dac_strobe !== 1'b0) begin n_fail++; $display("FAIL underrun_strobe: cycle %0d got %0b expected 0", c, dac_strobe); end
      n_chk++; if (dac_d !== 10'h001) begin n_fail++; $display("FAIL underrun_hold: got %0h expected 001", dac_d); end
      n_chk++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL underrun_ready: got %0b expected 00", req_ready); end
    end
  endtask

  // div=0 -> P=2; then div=20 lowered to 2 while cnt=10 wraps next cycle, then P=3.
  task automatic test_div_change();
    exp_t e;
    logic [1:0] prev_rdy;
    prev_rdy = '0;
    do_reset();
    div = 16'd0; req_valid = 2'b10; req_data = {10'h2A5, 10'h0F0}; enable = 1'b1;
    for (int k = 0; k < 3; k++) push_exp(4 + 2*k, 10'h2A5, 1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      if (dac_strobe) begin
        if (sb_q.size() == 0) begin
          n_chk++; n_fail++; $display("FAIL div0_extra_strobe: strobe at cycle %0d, expected none", c);
        end else begin
          e = sb_q.pop_front();
          n_chk++; if (c !== e.cyc) begin n_fail++; $display("FAIL div0_strobe_cycle: got %0d expected %0d", c, e.cyc); end
          n_chk++; if (dac_d !== e.d) begin n_fail++; $display("FAIL div0_dac_d: got %0h expected %0h", dac_d, e.d); end
          n_chk++; if (prev_rdy !== e.rdy) begin n_fail++; $display("FAIL div0_ready: got %0b expected %0b", prev_rdy, e.rdy); end
        end
      end
      prev_rdy = req_ready;
    end
    n_chk++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL div0_missing: %0d strobes outstanding, expected 0", sb_q.size()); end
    sb_q.delete();

    enable = 1'b0;
    @(negedge CLK);
    div = 16'd20; req_data = {10'h1C3, 10'h0F0}; enable = 1'b1; prev_rdy = '0;
    for (int k = 0; k < 4; k++) push_exp(13 + 3*k, 10'h1C3, 1);
    for (int c = 1; c <= 22; c++) begin
      @(negedge CLK);
      if (dac_strobe) begin
        if (sb_q.size() == 0) begin
          n_chk++; n_fail++; $display("FAIL divchg_extra_strobe: strobe at cycle %0d, expected none", c);
        end else begin
          e = sb_q.pop_front();
          n_chk++; if (c !== e.cyc) begin n_fail++; $display("FAIL divchg_strobe_cycle: got %0d expected %0d", c, e.cyc); end
          n_chk++; if (dac_d !== e.d) begin n_fail++; $display("FAIL divchg_dac_d: got %0h expected %0h", dac_d, e.d); end
          n_chk++; if (grant_id !== e.id) begin n_fail++; $display("FAIL divchg_grant_id: got %0d expected %0d", grant_id, e.id); end
        end
      end
      prev_rdy = req_ready;
      if (c == 11) div = 16'd2;
    end
    n_chk++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL divchg_missing: %0d strobes outstanding, expected 0", sb_q.size()); end
    sb_q.delete();
  endtask

  // Reset in the GRANT at cycle 9 and enable=0 in the GRANT at cycle 19 both cancel the transfer.
  task automatic test_abort_grant();
    exp_t e;
    logic [1:0] prev_rdy;
    prev_rdy = '0;
    do_reset();
    div = 16'd3; req_valid = 2'b11; req_data = {10'h001, 10'h3FF}; enable = 1'b1;
    push_exp(6, 10'h3FF, 0);
    push_exp(16, 10'h3FF, 0);
    push_exp(26, 10'h001, 1);
    for (int c = 1; c <= 26; c++) begin
      @(negedge CLK);
      if (dac_strobe) begin
        if (sb_q.size() == 0) begin
          n_chk++; n_fail++; $display("FAIL abort_extra_strobe: strobe at cycle %0d, expected none", c);
        end else begin
          e = sb_q.pop_front();
          n_chk++; if (c !== e.cyc) begin n_fail++; $display("FAIL abort_strobe_cycle: got %0d expected %0d", c, e.cyc); end
          n_chk++; if (dac_d !== e.d) begin n_fail++; $display("FAIL abort_dac_d: got %0h expected %0h", dac_d, e.d); end
          n_chk++; if (grant_id !== e.id) begin n_fail++; $display("FAIL abort_grant_id: got %0d expected %0d", grant_id, e.id); end
          n_chk++; if (prev_rdy !== e.rdy) begin n_fail++; $display("FAIL abort_ready: got %0b expected %0b", prev_rdy, e.rdy); end
        end
      end
      prev_rdy = req_ready;
      if (c == 9 || c == 19) begin
        n_chk++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL abort_grant_ready: cycle %0d got %0b expected 10", c, req_ready); end
        if (c == 9) reset = 1'b0;
        else        enable = 1'b0;
      end
      if (c == 10) begin
        n_chk++; if (dac_strobe !== 1'b0) begin n_fail++; $display("FAIL abort_rst_strobe: got %0b expected 0", dac_strobe); end
        n_chk++; if (dac_d !== 10'h000) begin n_fail++; $display("FAIL abort_rst_dac_d: got %0h expected 0", dac_d); end
        n_chk++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL abort_rst_grant_id: got %0d expected 0", grant_id); end
        reset = 1'b1;
      end
      if (c == 20) begin
        n_chk++; if (dac_strobe !== 1'b0) begin n_fail++; $display("FAIL abort_en_strobe: got %0b expected 0", dac_strobe); end
        n_chk++; if (dac_d !== 10'h3FF) begin n_fail++; $display("FAIL abort_en_dac_d: got %0h expected 3ff", dac_d); end
        n_chk++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL abort_en_underrun: got %0b expected 0", underrun); end
        enable = 1'b1;
      end
    end
    n_chk++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL abort_missing: %0d strobes outstanding, expected 0", sb_q.size()); end
    sb_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_underrun();
    test_div_change();
    test_abort_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
